// File: rtl/cfg_pkg.sv
// Shared constants, state type and frame-length helper for the config chain.
package cfg_pkg;

  localparam int unsigned DEF_SHIFT_LEN = 16;
  localparam int unsigned DEF_ID_WIDTH  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } cfg_state_e;

  function automatic int unsigned FRAME_LEN(input int unsigned id_width,
                                            input int unsigned shift_len);
    return id_width + shift_len;
  endfunction

endpackage

// File: rtl/cfg_piso.sv
// Loadable parallel-in/serial-out register; shifts MSB out first and fills with zeros,
// so it reads back 0 once a full frame has been shifted.
module cfg_piso #(
  parameter int unsigned WIDTH = 19
) (
  input  logic             clk,
  input  logic             crst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_par,
  output logic             o_sout
);

  logic [WIDTH-1:0] r_sr;

  always_ff @(posedge clk or posedge crst) begin
    if (crst) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_par;
    end else if (i_shift) begin
      r_sr <= r_sr << 1;
    end
  end

  assign o_sout = r_sr[WIDTH-1];

endmodule

// File: rtl/cfg_loader.sv
// Config-chain head transmitter: one addressed frame (ID MSB-first, payload LSB-first) per request.
// Optional tail monitor for unclaimed frames under `define CFG_LOADER_LOOPBACK_EN.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int unsigned SHIFT_LEN  = DEF_SHIFT_LEN,
  parameter int unsigned ID_WIDTH   = DEF_ID_WIDTH,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 crst,
  input  logic                 word_valid,
  output logic                 word_ready,
  input  logic [ID_WIDTH-1:0]  word_id,
  input  logic [SHIFT_LEN-1:0] word_data,
  output logic                 busy,
  output logic [15:0]          frames_sent,
  output logic                 cfg_in_start,
  output logic                 cfg_bit_in
`ifdef CFG_LOADER_LOOPBACK_EN
  ,
  input  logic                 chain_out_start,
  input  logic                 chain_bit_out,
  output logic [7:0]           unclaimed_cnt,
  output logic [ID_WIDTH-1:0]  unclaimed_id
`endif
);

  localparam int unsigned F  = FRAME_LEN(ID_WIDTH, SHIFT_LEN);
  localparam int unsigned CW = $clog2(F);
  localparam int unsigned GW = (GAP_CYCLES + 1 <= 2) ? 1 : $clog2(GAP_CYCLES + 1);

  cfg_state_e      r_state;
  logic [CW-1:0]   r_cnt;
  logic [GW-1:0]   r_gap;
  logic            r_start;
  logic [15:0]     r_frames;
  logic [F-1:0]    w_frame;
  logic            w_accept;

  // Payload is bit-reversed so a single MSB-first shifter yields ID MSB-first, payload LSB-first.
  always_comb begin
    w_frame = '0;
    w_frame[F-1 -: ID_WIDTH] = word_id;
    for (int unsigned i = 0; i < SHIFT_LEN; i++) begin
      w_frame[SHIFT_LEN-1-i] = word_data[i];
    end
  end

  assign w_accept = (r_state == IDLE) && word_valid;

  always_ff @(posedge clk or posedge crst) begin
    if (crst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_start  <= 1'b0;
      r_frames <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (word_valid) begin
            r_state <= SEND;
            r_cnt   <= '0;
            r_start <= 1'b1;
          end
        end
        SEND: begin
          r_start <= 1'b0;
          if (r_cnt == CW'(F - 1)) begin
            r_cnt    <= '0;
            r_frames <= r_frames + 16'd1;
            r_gap    <= '0;
            r_state  <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        GAP: begin
          if (r_gap == GW'(GAP_CYCLES - 1)) begin
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  cfg_piso #(.WIDTH(F)) u_piso (
    .clk     (clk),
    .crst    (crst),
    .i_load  (w_accept),
    .i_shift (r_state == SEND),
    .i_par   (w_frame),
    .o_sout  (cfg_bit_in)
  );

  assign word_ready   = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign cfg_in_start = r_start;
  assign frames_sent  = r_frames;

`ifdef CFG_LOADER_LOOPBACK_EN
  localparam int unsigned KW = $clog2(ID_WIDTH + 1);

  logic [ID_WIDTH-1:0] r_cap;
  logic [KW-1:0]       r_cap_cnt;
  logic                r_cap_act;
  logic [7:0]          r_unc_cnt;
  logic [ID_WIDTH-1:0] r_unc_id;

  // The tail start strobe coincides with the first ID bit, so capture begins in that cycle.
  always_ff @(posedge clk or posedge crst) begin
    if (crst) begin
      r_cap     <= '0;
      r_cap_cnt <= '0;
      r_cap_act <= 1'b0;
      r_unc_cnt <= '0;
      r_unc_id  <= '0;
    end else if (chain_out_start) begin
      r_cap     <= (r_cap << 1) | ID_WIDTH'(chain_bit_out);
      r_cap_cnt <= KW'(1);
      r_cap_act <= 1'b1;
      if (r_unc_cnt != 8'hFF) begin
        r_unc_cnt <= r_unc_cnt + 8'd1;
      end
    end else if (r_cap_act) begin
      if (r_cap_cnt == KW'(ID_WIDTH)) begin
        r_unc_id  <= r_cap;
        r_cap_act <= 1'b0;
      end else begin
        r_cap     <= (r_cap << 1) | ID_WIDTH'(chain_bit_out);
        r_cap_cnt <= r_cap_cnt + KW'(1);
      end
    end
  end

  assign unclaimed_cnt = r_unc_cnt;
  assign unclaimed_id  = r_unc_id;
`endif

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader: two instances (GAP_CYCLES=2 and 0) against a frame-level model.
module tb_cfg_loader;

  localparam int SL = 16;
  localparam int IW = 3;
  localparam int F  = IW + SL;

  logic          clk = 1'b0;
  logic          crst;
  logic [1:0]    word_valid;
  logic [IW-1:0] word_id;
  logic [SL-1:0] word_data;
  logic [1:0]    word_ready, busy, cfg_in_start, cfg_bit_in;
  logic [15:0]   frames_sent [2];
`ifdef CFG_LOADER_LOOPBACK_EN
  logic [7:0]    unc_cnt [2];
  logic [IW-1:0] unc_id  [2];
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int exp_frames [2];
  int prev_start [2];
  bit prev_kept  [2];
  int exp_unc;
  logic [IW-1:0] exp_uid;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cfg_loader #(.SHIFT_LEN(SL), .ID_WIDTH(IW), .GAP_CYCLES(2)) u_dut0 (
    .clk(clk), .crst(crst), .word_valid(word_valid[0]), .word_ready(word_ready[0]),
    .word_id(word_id), .word_data(word_data), .busy(busy[0]), .frames_sent(frames_sent[0]),
    .cfg_in_start(cfg_in_start[0]), .cfg_bit_in(cfg_bit_in[0])
`ifdef CFG_LOADER_LOOPBACK_EN
    , .chain_out_start(cfg_in_start[0]), .chain_bit_out(cfg_bit_in[0]),
    .unclaimed_cnt(unc_cnt[0]), .unclaimed_id(unc_id[0])
`endif
  );

  cfg_loader #(.SHIFT_LEN(SL), .ID_WIDTH(IW), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .crst(crst), .word_valid(word_valid[1]), .word_ready(word_ready[1]),
    .word_id(word_id), .word_data(word_data), .busy(busy[1]), .frames_sent(frames_sent[1]),
    .cfg_in_start(cfg_in_start[1]), .cfg_bit_in(cfg_bit_in[1])
`ifdef CFG_LOADER_LOOPBACK_EN
    , .chain_out_start(cfg_in_start[1]), .chain_bit_out(cfg_bit_in[1]),
    .unclaimed_cnt(unc_cnt[1]), .unclaimed_id(unc_id[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gap_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  // Reference frame: bit i of the frame as it appears on the wire.
  function automatic logic frame_bit(input logic [IW-1:0] id, input logic [SL-1:0] d, input int i);
    if (i < IW) return id[IW-1-i];
    return d[i-IW];
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      exp_frames[u] = 0;
      prev_kept[u]  = 1'b0;
    end
    exp_unc = 0;
    exp_uid = '0;
  endtask

  task automatic do_frame(input int u, input logic [IW-1:0] id, input logic [SL-1:0] d,
                          input bit keep, input bit toggle);
    int waited = 0;
    word_id = id;
    word_data = d;
    word_valid[u] = 1'b1;
    while (word_ready[u] !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) begin
      chk("ready_timeout", 32'(word_ready[u]), 32'd1);
      word_valid[u] = 1'b0;
      return;
    end
    tick();
    if (!keep) word_valid[u] = 1'b0;
    for (int i = 0; i < F; i++) begin
      if (i == 0) begin
        if (prev_kept[u]) chk("strobe_spacing", 32'(cyc - prev_start[u]), 32'(F + gap_of(u) + 1));
        prev_start[u] = cyc;
      end
      chk("start", 32'(cfg_in_start[u]), 32'(i == 0));
      chk("bit", 32'(cfg_bit_in[u]), 32'(frame_bit(id, d, i)));
      chk("ready_send", 32'(word_ready[u]), 32'd0);
      chk("busy_send", 32'(busy[u]), 32'd1);
      if (keep) begin
        word_id = IW'($urandom);
        word_data = SL'($urandom);
      end else if (toggle) begin
        word_valid[u] = 1'($urandom);
        word_id = IW'($urandom);
        word_data = SL'($urandom);
      end
      tick();
    end
    if (!keep) word_valid[u] = 1'b0;
    exp_frames[u]++;
    for (int g = 0; g < gap_of(u); g++) begin
      chk("gap_bit", 32'(cfg_bit_in[u]), 32'd0);
      chk("gap_start", 32'(cfg_in_start[u]), 32'd0);
      chk("ready_gap", 32'(word_ready[u]), 32'd0);
      chk("busy_gap", 32'(busy[u]), 32'd1);
      tick();
    end
    chk("ready_idle", 32'(word_ready[u]), 32'd1);
    chk("busy_idle", 32'(busy[u]), 32'd0);
    chk("frames_sent", 32'(frames_sent[u]), 32'(16'(exp_frames[u])));
    prev_kept[u] = keep;
`ifdef CFG_LOADER_LOOPBACK_EN
    if (u == 0) begin
      exp_unc = (exp_unc < 255) ? exp_unc + 1 : 255;
      exp_uid = id;
      chk("unclaimed_cnt", 32'(unc_cnt[0]), 32'(exp_unc));
      chk("unclaimed_id", 32'(unc_id[0]), 32'(exp_uid));
    end
`endif
  endtask

  task automatic check_reset_values(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk({tag, "_ready"}, 32'(word_ready[u]), 32'd1);
      chk({tag, "_busy"}, 32'(busy[u]), 32'd0);
      chk({tag, "_frames"}, 32'(frames_sent[u]), 32'd0);
      chk({tag, "_start"}, 32'(cfg_in_start[u]), 32'd0);
      chk({tag, "_bit"}, 32'(cfg_bit_in[u]), 32'd0);
`ifdef CFG_LOADER_LOOPBACK_EN
      chk({tag, "_unc_cnt"}, 32'(unc_cnt[u]), 32'd0);
      chk({tag, "_unc_id"}, 32'(unc_id[u]), 32'd0);
`endif
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    crst = 1'b1;
    word_valid = '0;
    word_id = '0;
    word_data = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_values("reset");
    #2 crst = 1'b0;
    tick();
    check_reset_values("post_reset");

    // Directed frame from the plan, then back-to-back pairs on both gap settings.
    do_frame(0, 3'd5, 16'hA5C3, 1'b0, 1'b0);
    do_frame(0, IW'($urandom), SL'($urandom), 1'b1, 1'b0);
    do_frame(0, IW'($urandom), SL'($urandom), 1'b0, 1'b0);
    do_frame(1, IW'($urandom), SL'($urandom), 1'b1, 1'b0);
    do_frame(1, IW'($urandom), SL'($urandom), 1'b0, 1'b0);
    do_frame(0, IW'($urandom), SL'($urandom), 1'b0, 1'b1);
    do_frame(1, IW'($urandom), SL'($urandom), 1'b0, 1'b1);

    // Reset in the eighth bit cycle of a frame whose eighth bit is 1.
    chk("pre_abort_ready", 32'(word_ready[0]), 32'd1);
    word_id = 3'd2;
    word_data = 16'h0010;
    word_valid[0] = 1'b1;
    tick();
    word_valid[0] = 1'b0;
    repeat (7) tick();
    chk("abort_bit_before", 32'(cfg_bit_in[0]), 32'd1);
    chk("abort_busy_before", 32'(busy[0]), 32'd1);
    #2 crst = 1'b1;
    model_reset();
    #1;
    check_reset_values("abort");
    #1 crst = 1'b0;
    tick();
    do_frame(0, 3'd6, 16'h1234, 1'b0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      for (int u = 0; u < 2; u++) begin
        do_frame(u, IW'($urandom), SL'($urandom), (k % 3 != 2) && 1'($urandom), 1'($urandom));
        if (prev_kept[u]) do_frame(u, IW'($urandom), SL'($urandom), 1'b0, 1'b0);
      end
    end

`ifdef CFG_LOADER_LOOPBACK_EN
    for (int k = 0; k < 260; k++) begin
      do_frame(0, 3'd7, SL'($urandom), 1'b0, 1'b0);
    end
    chk("unclaimed_saturated", 32'(unc_cnt[0]), 32'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
